// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: replays 32-bit words from a first-word-fall-through FIFO as
// an 8-bit DVP camera stream (vsync / href / data) with programmable timing.
// Optional build macro DVP_FRAME_TX_PATTERN_EN adds input test_mode, which
// replaces FIFO data with the horizontal byte index.
// rd_ack is high during the clock whose closing edge loads byte [7:0] onto
// camera_data. The FIFO therefore pops on the same edge that emits [7:0],
// and the next head word is stable in time for the next group's byte 0.
`timescale 1ns/1ps
module dvp_frame_tx #(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 720,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 20,
    parameter int V_FRONT  = 5
) (
    input  logic        camera_pclk,
    input  logic        rst,
    input  logic        init_done,
`ifdef DVP_FRAME_TX_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    output logic        rd_ack,
    output logic        camera_vsync,
    output logic        camera_href,
    output logic [7:0]  camera_data,
    output logic        frame_done,
    output logic        underflow
);
    localparam int H_TOTAL   = H_ACTIVE + H_BLANK;
    localparam int SYNC_LEN  = V_SYNC * H_TOTAL;
    localparam int BACK_LEN  = V_BACK * H_TOTAL;
    localparam int FRONT_LEN = V_FRONT * H_TOTAL;
    localparam int L1 = (SYNC_LEN > BACK_LEN) ? SYNC_LEN : BACK_LEN;
    localparam int L2 = (L1 > FRONT_LEN) ? L1 : FRONT_LEN;
    localparam int L3 = (L2 > H_TOTAL) ? L2 : H_TOTAL;
    // One counter serves every state; it only has to reach the longest one.
    localparam int CW = (L3 > 4) ? $clog2(L3) : 2;
    localparam int LW = $clog2(V_ACTIVE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]  line_q, line_d;
    logic [1:0]     init_q;
    logic [23:0]    word_q, word_d;
    logic           ok_q, ok_d;
    logic           vsync_q, vsync_d;
    logic           href_q, href_d;
    logic [7:0]     data_q, data_d;
    logic           done_q, done_d;
    logic           underflow_q, underflow_d;
    logic           grp_start;
    logic           pat;

`ifdef DVP_FRAME_TX_PATTERN_EN
    assign pat = test_mode;
`else
    assign pat = 1'b0;
`endif

    // Frame sequencer: state, position inside the state, and lines sent.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        line_d  = line_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (init_q[1]) state_d = S_VSYNC;
            end
            S_VSYNC: begin
                if (cnt_q == CW'(SYNC_LEN - 1)) begin
                    state_d = S_VBACK;
                    cnt_d   = '0;
                end
            end
            S_VBACK: begin
                if (cnt_q == CW'(BACK_LEN - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end
            end
            S_ACTIVE: begin
                if (cnt_q == CW'(H_ACTIVE - 1)) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                    line_d  = line_q + LW'(1);
                end
            end
            S_HBLANK: begin
                if (cnt_q == CW'(H_BLANK - 1)) begin
                    cnt_d = '0;
                    if (line_q < LW'(V_ACTIVE)) begin
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_VFRONT;
                        line_d  = '0;
                    end
                end
            end
            S_VFRONT: begin
                if (cnt_q == CW'(FRONT_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = init_done ? S_VSYNC : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the next clock, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        grp_start   = (state_d == S_ACTIVE) && (cnt_d[1:0] == 2'd0);
        vsync_d     = (state_d == S_VSYNC);
        href_d      = (state_d == S_ACTIVE);
        done_d      = (state_d == S_VFRONT) && (cnt_d == CW'(FRONT_LEN - 1));
        word_d      = word_q;
        ok_d        = ok_q;
        underflow_d = underflow_q;
        data_d      = 8'h00;
        if (href_d) begin
            if (pat) begin
                data_d = 8'(cnt_d);
                if (grp_start) ok_d = 1'b0;
            end else if (grp_start) begin
                // Latch the head word; a starved slot goes out as zeros.
                word_d      = rd_data[23:0];
                ok_d        = !rd_empty;
                data_d      = rd_empty ? 8'h00 : rd_data[31:24];
                underflow_d = underflow_q | rd_empty;
            end else if (ok_q) begin
                unique case (cnt_d[1:0])
                    2'd1:    data_d = word_q[23:16];
                    2'd2:    data_d = word_q[15:8];
                    default: data_d = word_q[7:0];
                endcase
            end
        end
    end

    // State, counters and registered outputs; reset clears everything.
    always_ff @(posedge camera_pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            init_q      <= '0;
            word_q      <= '0;
            ok_q        <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            init_q      <= {init_q[0], init_done};
            word_q      <= word_d;
            ok_q        <= ok_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    // Pop while byte [15:8] is on the bus so the FIFO advances as [7:0] goes out.
    assign rd_ack = (state_q == S_ACTIVE) && (cnt_q[1:0] == 2'd2) && ok_q &&
                    !rd_empty && !pat;

    assign camera_vsync = vsync_q;
    assign camera_href  = href_q;
    assign camera_data  = data_q;
    assign frame_done   = done_q;
    assign underflow    = underflow_q;
endmodule
